// File: rtl/jump_lut.sv
`default_nettype none
// ============================================================================
// Module      : jump_lut
// Description : Writable jump-key to PC-target lookup table. It fills itself
//               with i*STRIDE after reset. Reads are registered and carry a
//               one-cycle valid. Run-time writes come from decode.
//               Optional macro LUT_BYPASS_EN: a same-cycle read and write to
//               the same key forwards the write data (write-first). When the
//               macro is undefined, that read returns the old entry.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_lut #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int STRIDE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] Addr,
    output logic              RdValid,
    output logic [DATA_W-1:0] Target,
    output logic              OutOfRange,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              Busy
);

    localparam logic [0:0]        c_st_init  = 1'b0;
    localparam logic [0:0]        c_st_ready = 1'b1;
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_target;
    logic              r_oor;
    logic              w_rd_in_range;
    logic              w_wr_in_range;
    logic [31:0]       w_init_prod;
    logic [DATA_W-1:0] w_init_val;
    logic [DATA_W-1:0] w_rd_data;

    // Keys are compared one bit wider so DEPTH == 2**ADDR_W needs no special case.
    assign w_rd_in_range = ({1'b0, Addr}   < c_depth);
    assign w_wr_in_range = ({1'b0, WrAddr} < c_depth);

    // Default content: the init counter times STRIDE, truncated to the target width.
    assign w_init_prod = 32'(r_cnt) * 32'(STRIDE);
    assign w_init_val  = DATA_W'(w_init_prod);

    assign Busy       = (r_state == c_st_init);
    assign RdValid    = r_rd_valid;
    assign Target     = r_target;
    assign OutOfRange = r_oor;

    // State and init-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_init;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: step through every entry once, then stay READY until reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_init: begin
                w_cnt_nxt = r_cnt + c_one;
                if (r_cnt == c_last) begin
                    w_state_nxt = c_st_ready;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_st_ready;
            end
        endcase
    end

    // Read-data source. Forwarding covers only an in-range write that hits the read key.
    always_comb begin
        w_rd_data = r_mem[Addr];
`ifdef LUT_BYPASS_EN
        if (WrEn && w_wr_in_range && (WrAddr == Addr)) begin
            w_rd_data = WrData;
        end
`endif
    end

    // Table storage. Init fill takes priority, and writes are accepted only when READY and in range.
    always_ff @(posedge clk) begin
        if (r_state == c_st_init) begin
            r_mem[r_cnt] <= w_init_val;
        end else if (WrEn && w_wr_in_range) begin
            r_mem[WrAddr] <= WrData;
        end
    end

    // Registered read port. Target holds its value while idle, and an out-of-range read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_target   <= '0;
            r_oor      <= 1'b0;
        end else if (r_state == c_st_ready) begin
            r_rd_valid <= RdReq;
            r_oor      <= 1'b0;
            if (RdReq) begin
                if (w_rd_in_range) begin
                    r_target <= w_rd_data;
                end else begin
                    r_target <= '0;
                    r_oor    <= 1'b1;
                end
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_oor      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jump_lut.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_lut
// Description : Directed self-checking bench for jump_lut. It drives a
//               DEPTH=16 instance and a DEPTH=12 instance from one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_lut;

    logic       clk;
    logic       rst_n;

    logic       rd16, wr16, valid16, oor16, busy16;
    logic [3:0] addr16, wraddr16;
    logic [9:0] wrdata16, target16;

    logic       rd12, wr12, valid12, oor12, busy12;
    logic [3:0] addr12, wraddr12;
    logic [9:0] wrdata12, target12;

    int checks   = 0;
    int failures = 0;

    jump_lut #(.ADDR_W(4), .DATA_W(10), .DEPTH(16), .STRIDE(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .RdReq(rd16), .Addr(addr16),
        .RdValid(valid16), .Target(target16), .OutOfRange(oor16),
        .WrEn(wr16), .WrAddr(wraddr16), .WrData(wrdata16),
        .Busy(busy16)
    );

    jump_lut #(.ADDR_W(4), .DATA_W(10), .DEPTH(12), .STRIDE(8)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .RdReq(rd12), .Addr(addr12),
        .RdValid(valid12), .Target(target12), .OutOfRange(oor12),
        .WrEn(wr12), .WrAddr(wraddr12), .WrData(wrdata12),
        .Busy(busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd16 = 1'b1; addr16 = 4'd3; wr16 = 1'b0; wraddr16 = '0; wrdata16 = '0;
        rd12 = 1'b0; addr12 = '0;   wr12 = 1'b0; wraddr12 = '0; wrdata12 = '0;

        // Hold reset over a few edges with a read request pending.
        step; step; step;
        chk("rst_valid",  32'(valid16),  32'd0);
        chk("rst_target", 32'(target16), 32'd0);
        chk("rst_oor",    32'(oor16),    32'd0);
        chk("rst_busy",   32'(busy16),   32'd1);

        // Release mid-cycle. Busy stays high through edge 15 and falls after edge 16.
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step;
            chk($sformatf("init_busy_e%0d", i), 32'(busy16), (i < 16) ? 32'd1 : 32'd0);
            chk($sformatf("init_valid_e%0d", i), 32'(valid16), 32'd0);
        end
        // The request sampled at edge 17 is the first one served.
        step;
        chk("first_valid",  32'(valid16),  32'd1);
        chk("first_target", 32'(target16), 32'd24);
        chk("first_oor",    32'(oor16),    32'd0);

        // Read every key back-to-back.
        for (int k = 0; k < 16; k++) begin
            addr16 = 4'(k);
            step;
            chk($sformatf("seq_valid_k%0d", k),  32'(valid16),  32'd1);
            chk($sformatf("seq_target_k%0d", k), 32'(target16), 32'(k * 8));
        end

        // Write key 5 = 0x3FF with no read. Target should hold its last value.
        rd16 = 1'b0; wr16 = 1'b1; wraddr16 = 4'd5; wrdata16 = 10'h3FF;
        step;
        chk("idle_valid",  32'(valid16),  32'd0);
        chk("idle_hold",   32'(target16), 32'd120);
        chk("idle_oor",    32'(oor16),    32'd0);
        wr16 = 1'b0; rd16 = 1'b1; addr16 = 4'd5;
        step;
        chk("wr5_read", 32'(target16), 32'd1023);

        // Write key 15 = 0, then read it back.
        rd16 = 1'b0; wr16 = 1'b1; wraddr16 = 4'd15; wrdata16 = 10'd0;
        step;
        wr16 = 1'b0; rd16 = 1'b1; addr16 = 4'd15;
        step;
        chk("wr15_read", 32'(target16), 32'd0);

        // Read key 7 and write key 7 in the same cycle.
        rd16 = 1'b1; addr16 = 4'd7; wr16 = 1'b1; wraddr16 = 4'd7; wrdata16 = 10'd500;
        step;
`ifdef LUT_BYPASS_EN
        chk("same_key_rw", 32'(target16), 32'd500);
`else
        chk("same_key_rw", 32'(target16), 32'd56);
`endif
        wr16 = 1'b0;
        step;
        chk("same_key_after", 32'(target16), 32'd500);

        // Read key 4 and write key 6 in the same cycle. The two are independent.
        addr16 = 4'd4; wr16 = 1'b1; wraddr16 = 4'd6; wrdata16 = 10'd100;
        step;
        chk("diff_key_read", 32'(target16), 32'd32);
        wr16 = 1'b0; addr16 = 4'd6;
        step;
        chk("diff_key_after", 32'(target16), 32'd100);

        // DEPTH=12 instance: in-range read, then out-of-range read, then a dropped write.
        chk("d12_busy", 32'(busy12), 32'd0);
        rd12 = 1'b1; addr12 = 4'd11;
        step;
        chk("d12_k11", 32'(target12), 32'd88);
        addr12 = 4'd13;
        step;
        chk("d12_oor_valid",  32'(valid12),  32'd1);
        chk("d12_oor_flag",   32'(oor12),    32'd1);
        chk("d12_oor_target", 32'(target12), 32'd0);
        rd12 = 1'b0; wr12 = 1'b1; wraddr12 = 4'd14; wrdata12 = 10'h155;
        step;
        chk("d12_idle_oor", 32'(oor12), 32'd0);
        wr12 = 1'b0; rd12 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            addr12 = 4'(k);
            step;
            chk($sformatf("d12_k%0d", k), 32'(target12), 32'(k * 8));
            chk($sformatf("d12_oor_k%0d", k), 32'(oor12), 32'd0);
        end
        rd12 = 1'b0;
        step;
        chk("d12_hold", 32'(target12), 32'd88);

        // Write key 2 = 777, confirm it, then assert reset in the middle of a read stream.
        rd16 = 1'b0; wr16 = 1'b1; wraddr16 = 4'd2; wrdata16 = 10'd777;
        step;
        wr16 = 1'b0; rd16 = 1'b1; addr16 = 4'd2;
        step;
        chk("wr2_read", 32'(target16), 32'd777);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid",  32'(valid16),  32'd0);
        chk("async_target", 32'(target16), 32'd0);
        chk("async_oor",    32'(oor16),    32'd0);
        chk("async_busy",   32'(busy16),   32'd1);
        rd16 = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step;
        end
        chk("reinit_busy", 32'(busy16), 32'd0);
        rd16 = 1'b1; addr16 = 4'd2;
        step;
        chk("reinit_valid", 32'(valid16),  32'd1);
        chk("reinit_k2",    32'(target16), 32'd16);
        rd16 = 1'b0;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
